mux_nch_reg: RTL and testbench

Parametrised N-channel registered selector with valid/ready handshaking. It is the pipelined successor to the datapath's plain 2:1 word multiplexer. Each cycle it picks one requesting input channel, either by an external `select` or by round-robin arbitration, and captures that channel's word in a single output register stage. It sits between multiple producers (ALU result, memory read data, immediate path, writeback sources) and a single consumer that may stall.

---
 rtl/mux_nch_reg.sv | 91 +++++++++
 tb/tb_mux_nch_reg.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nch_reg.sv
// N-channel registered selector with valid/ready handshaking.
// A channel is chosen by external select or by round-robin and is captured in one output register.
module mux_nch_reg #(
    parameter int word_size = 32,
    parameter int channels  = 4,
    parameter int sel_width = 2,
    parameter int arb_mode  = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [channels*word_size-1:0] input_data,
    input  logic [channels-1:0]           input_valid,
    output logic [channels-1:0]           input_ready,
    input  logic [sel_width-1:0]          select,
    output logic [word_size-1:0]          output_data,
    output logic                          output_valid,
    input  logic                          output_ready,
    output logic [sel_width-1:0]          output_channel
);

    logic                 load_en;
    logic                 grant_valid;
    logic [sel_width-1:0] grant;
    logic [sel_width-1:0] ptr;
    logic [sel_width-1:0] ptr_next;
    logic [word_size-1:0] grant_word;

    assign load_en = !output_valid || output_ready;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        if (arb_mode == 0) begin
            // Out-of-range select matches no channel index, so it never grants.
            for (int i = 0; i < channels; i++) begin
                if (!grant_valid && select == sel_width'(i) && input_valid[i]) begin
                    grant       = sel_width'(i);
                    grant_valid = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < channels; k++) begin
                int idx;
                idx = int'(ptr) + k;
                if (idx >= channels) idx = idx - channels;
                if (!grant_valid && input_valid[idx]) begin
                    grant       = sel_width'(idx);
                    grant_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_word = '0;
        for (int i = 0; i < channels; i++) begin
            if (grant == sel_width'(i)) grant_word = input_data[i*word_size +: word_size];
        end
    end

    // Explicit wrap so a non-power-of-2 channel count never lands on an unused index.
    assign ptr_next = (int'(grant) == channels - 1) ? '0 : grant + sel_width'(1);

    always_comb begin
        input_ready = '0;
        for (int i = 0; i < channels; i++) begin
            input_ready[i] = !reset && load_en && grant_valid && (grant == sel_width'(i));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            output_valid   <= 1'b0;
            output_data    <= '0;
            output_channel <= '0;
            ptr            <= '0;
        end else if (load_en) begin
            if (grant_valid) begin
                output_data    <= grant_word;
                output_channel <= grant;
                output_valid   <= 1'b1;
                if (arb_mode != 0) ptr <= ptr_next;
            end else begin
                output_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nch_reg.sv
// Bench for mux_nch_reg: external-select, 4-channel round-robin and 3-channel round-robin instances,
// checked against a reference arbiter model and a scoreboard of expected output words.
module tb_mux_nch_reg;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  ch;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] word [3][4];
    logic [127:0] flat [3];
    logic [3:0]  valid [3];
    logic [1:0]  sel [3];
    logic        ordy [3];

    logic [3:0]  ir_a, ir_b;
    logic [2:0]  ir_c;
    logic [3:0]  iready [3];
    logic [31:0] odata [3];
    logic        ovalid [3];
    logic [1:0]  och [3];

    exp_t sb[$];
    int   mptr [3];
    int   nch [3]  = '{4, 4, 3};
    int   mode [3] = '{0, 1, 1};
    int   checks   = 0;
    int   failures = 0;

    always_comb begin
        for (int d = 0; d < 3; d++) begin
            flat[d] = '0;
            for (int i = 0; i < 4; i++) flat[d][i*32 +: 32] = word[d][i];
        end
    end

    always_comb begin
        iready[0] = ir_a;
        iready[1] = ir_b;
        iready[2] = {1'b0, ir_c};
    end

    mux_nch_reg #(.word_size(32), .channels(4), .sel_width(2), .arb_mode(0)) dut_sel (
        .clk(clk), .reset(reset), .input_data(flat[0]), .input_valid(valid[0]),
        .input_ready(ir_a), .select(sel[0]), .output_data(odata[0]), .output_valid(ovalid[0]),
        .output_ready(ordy[0]), .output_channel(och[0])
    );

    mux_nch_reg #(.word_size(32), .channels(4), .sel_width(2), .arb_mode(1)) dut_rr4 (
        .clk(clk), .reset(reset), .input_data(flat[1]), .input_valid(valid[1]),
        .input_ready(ir_b), .select(sel[1]), .output_data(odata[1]), .output_valid(ovalid[1]),
        .output_ready(ordy[1]), .output_channel(och[1])
    );

    mux_nch_reg #(.word_size(32), .channels(3), .sel_width(2), .arb_mode(1)) dut_rr3 (
        .clk(clk), .reset(reset), .input_data(flat[2][95:0]), .input_valid(valid[2][2:0]),
        .input_ready(ir_c), .select(sel[2]), .output_data(odata[2]), .output_valid(ovalid[2]),
        .output_ready(ordy[2]), .output_channel(och[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    function automatic int model_grant(input int d, input logic [3:0] v, input logic [1:0] s);
        if (mode[d] == 0) begin
            if (int'(s) < nch[d] && v[s]) return int'(s);
            return -1;
        end
        for (int k = 0; k < nch[d]; k++) begin
            int idx;
            idx = (mptr[d] + k) % nch[d];
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock cycle on instance d: compare held output with scoreboard head, drive inputs,
    // compare input_ready with the model, clock, then retire/push scoreboard entries.
    task automatic cyc(input int d, input logic [3:0] v, input logic [1:0] s, input logic r,
                       input string name);
        logic       held;
        logic       load;
        logic [3:0] exp_ir;
        int         g;
        held = (sb.size() > 0);
        checks++;
        if (held) begin
            if (ovalid[d] !== 1'b1 || odata[d] !== sb[0].data || och[d] !== sb[0].ch) begin
                failures++;
                $display("FAIL %s out: valid=%b data=%h ch=%0d expected valid=1 data=%h ch=%0d",
                         name, ovalid[d], odata[d], och[d], sb[0].data, sb[0].ch);
            end
        end else if (ovalid[d] !== 1'b0) begin
            failures++;
            $display("FAIL %s out_valid: actual=%b expected=0", name, ovalid[d]);
        end
        valid[d] = v;
        sel[d]   = s;
        ordy[d]  = r;
        #1;
        load   = !held || r;
        g      = model_grant(d, v, s);
        exp_ir = (load && g >= 0) ? 4'(1 << g) : 4'b0000;
        checks++;
        if (iready[d] !== exp_ir) begin
            failures++;
            $display("FAIL %s input_ready: actual=%b expected=%b", name, iready[d], exp_ir);
        end
        @(posedge clk);
        #1;
        if (held && r) void'(sb.pop_front());
        if (load && g >= 0) begin
            sb.push_back('{data: word[d][g], ch: 2'(g)});
            if (mode[d] != 0) mptr[d] = (g + 1) % nch[d];
            word[d][g] = $urandom;
        end
    endtask

    task automatic drain(input int d, input string name);
        cyc(d, 4'b0000, 2'd0, 1'b1, name);
        cyc(d, 4'b0000, 2'd0, 1'b1, name);
    endtask

    task automatic check_cleared(input string name);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ovalid[d] !== 1'b0 || odata[d] !== 32'h0 || och[d] !== 2'd0) begin
                failures++;
                $display("FAIL %s dut%0d: valid=%b data=%h ch=%0d expected 0/0/0",
                         name, d, ovalid[d], odata[d], och[d]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            valid[d] = 4'hF;
            sel[d]   = 2'd0;
            ordy[d]  = 1'b1;
        end
        repeat (2) begin
            #1;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (iready[d] !== 4'b0000) begin
                    failures++;
                    $display("FAIL reset_ready dut%0d: actual=%b expected=0000", d, iready[d]);
                end
            end
            @(posedge clk);
            #1;
        end
        check_cleared("reset_regs");
        valid[0] = 4'b0000;
        valid[2] = 4'b0000;
        reset    = 1'b0;
        sb.delete();
        mptr = '{0, 0, 0};
        #1;
        checks++;
        if (ir_b !== 4'b0001) begin
            failures++;
            $display("FAIL rst_first_grant: actual=%b expected=0001", ir_b);
        end
        cyc(1, 4'hF, 2'd0, 1'b1, "rst_first");
    endtask

    task automatic test_fairness();
        for (int n = 0; n < 8; n++) cyc(1, 4'hF, 2'd0, 1'b1, "rr4_fair");
        drain(1, "rr4_fair_drain");
    endtask

    task automatic test_select();
        word[0][2] = 32'hDEADBEEF;
        cyc(0, 4'b0100, 2'd2, 1'b1, "m0_sel2");
        checks++;
        if (odata[0] !== 32'hDEADBEEF || och[0] !== 2'd2 || ovalid[0] !== 1'b1) begin
            failures++;
            $display("FAIL m0_deadbeef: data=%h ch=%0d valid=%b expected deadbeef/2/1",
                     odata[0], och[0], ovalid[0]);
        end
        cyc(0, 4'b0111, 2'd3, 1'b1, "m0_sel3_invalid");
        checks++;
        if (ovalid[0] !== 1'b0 || odata[0] !== 32'hDEADBEEF || och[0] !== 2'd2) begin
            failures++;
            $display("FAIL m0_no_grant_hold: valid=%b data=%h ch=%0d expected 0/deadbeef/2",
                     ovalid[0], odata[0], och[0]);
        end
        cyc(0, 4'b0010, 2'd0, 1'b1, "m0_sel0_other_valid");
        cyc(0, 4'b0010, 2'd1, 1'b1, "m0_sel1");
        cyc(0, 4'b1000, 2'd3, 1'b1, "m0_sel3");
        drain(0, "m0_drain");
    endtask

    task automatic test_backpressure();
        cyc(1, 4'b0010, 2'd0, 1'b1, "bp_load_ch1");
        repeat (3) cyc(1, 4'b0010, 2'd0, 1'b0, "bp_stall");
        cyc(1, 4'b0010, 2'd0, 1'b1, "bp_drain_and_load");
        cyc(1, 4'b0000, 2'd0, 1'b1, "bp_last");
        drain(1, "bp_drain");
    endtask

    task automatic test_wrap3();
        repeat (4) cyc(2, 4'b0101, 2'd0, 1'b1, "rr3_sparse");
        cyc(2, 4'b0010, 2'd0, 1'b1, "rr3_ch1");
        cyc(2, 4'b0111, 2'd0, 1'b1, "rr3_ptr2");
        cyc(2, 4'b0111, 2'd0, 1'b1, "rr3_wrap0");
        drain(2, "rr3_drain");
    endtask

    task automatic test_reset_midstream();
        cyc(1, 4'b0100, 2'd0, 1'b1, "mid_load_ch2");
        reset    = 1'b1;
        valid[1] = 4'hF;
        #1;
        checks++;
        if (ir_b !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset_ready: actual=%b expected=0000", ir_b);
        end
        @(posedge clk);
        #1;
        check_cleared("mid_reset_regs");
        reset = 1'b0;
        sb.delete();
        mptr = '{0, 0, 0};
        cyc(1, 4'b1010, 2'd0, 1'b1, "mid_first_grant");
        checks++;
        if (och[1] !== 2'd1 || ovalid[1] !== 1'b1) begin
            failures++;
            $display("FAIL mid_lowest_valid: ch=%0d valid=%b expected ch=1 valid=1", och[1], ovalid[1]);
        end
        drain(1, "mid_drain");
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            valid[d] = 4'b0000;
            sel[d]   = 2'd0;
            ordy[d]  = 1'b0;
            for (int i = 0; i < 4; i++) word[d][i] = $urandom;
        end
        test_reset();
        test_fairness();
        test_select();
        test_backpressure();
        test_wrap3();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
